// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM state encoding, default data width and counter widths for the UART RX path
package uart_rx_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int EDGE_W = 5;
    localparam int BIT_W = 4;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
endpackage

// File: rtl/uart_rx_fsm_edge_bit_counter.sv
// edge_bit_counter: oversampling edge counter with bit index, cleared whenever counting is disabled
module edge_bit_counter
    import uart_rx_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              cnt_en,
    input  logic [EDGE_W-1:0] prescale,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              bit_end
);
    assign bit_end = edge_cnt == prescale - EDGE_W'(1);
    // edge counter wraps at the bit end and advances the bit index
    always_ff @(posedge CLK) begin
        if (RST || !cnt_en) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (bit_end) begin
            edge_cnt <= '0;
            bit_cnt  <= bit_cnt + BIT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + EDGE_W'(1);
        end
    end
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame controller; define UART_RX_FRAME_ERR_EN to add the frame_err output
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              RX_IN,
    input  logic              PAR_EN,
    input  logic [EDGE_W-1:0] prescale,
    input  logic              strt_glitch,
    input  logic              par_err,
    input  logic              stp_err,
    output logic [EDGE_W-1:0] edge_cnt,
    output logic [BIT_W-1:0]  bit_cnt,
    output logic              dat_samp_en,
    output logic              strt_check_en,
    output logic              deser_en,
    output logic              par_check_en,
    output logic              stp_check_en,
    output logic              data_valid
`ifdef UART_RX_FRAME_ERR_EN
    ,
    output logic              frame_err
`endif
);
    state_t            r_state, w_next;
    logic [EDGE_W-1:0] r_prescale;
    logic              r_par_en, r_err;
    logic              w_bit_end, w_cnt_en, w_strobe, w_frame_end;

    // counting stops (and clears) on the same edge that returns to IDLE, so IDLE always sees zeros
    assign w_cnt_en    = (r_state != IDLE) && (w_next != IDLE);
    assign w_frame_end = (r_state == STOP) && w_bit_end;

    edge_bit_counter u_cnt (
        .CLK      (CLK),
        .RST      (RST),
        .cnt_en   (w_cnt_en),
        .prescale (r_prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (w_bit_end)
    );

    // state register
    always_ff @(posedge CLK) begin
        r_state <= RST ? IDLE : w_next;
    end

    // next-state: check results are consumed at the bit end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = RX_IN ? IDLE : START;
            START:   w_next = w_bit_end ? (strt_glitch ? IDLE : DATA) : START;
            DATA:    w_next = (w_bit_end && bit_cnt == BIT_W'(DATA_WIDTH)) ? (r_par_en ? PARITY : STOP) : DATA;
            PARITY:  w_next = w_bit_end ? STOP : PARITY;
            STOP:    w_next = w_bit_end ? IDLE : STOP;
            default: w_next = IDLE;
        endcase
    end

    // strobes decoded from registered state and counters only
    always_comb begin
        w_strobe      = edge_cnt == r_prescale - EDGE_W'(2);
        dat_samp_en   = r_state != IDLE;
        strt_check_en = (r_state == START) && w_strobe;
        deser_en      = (r_state == DATA) && w_strobe;
        par_check_en  = (r_state == PARITY) && w_strobe;
        stp_check_en  = (r_state == STOP) && w_strobe;
    end

    // frame configuration capture in IDLE, parity error flag and frame verdict
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prescale <= '0;
            r_par_en   <= 1'b0;
            r_err      <= 1'b0;
            data_valid <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err  <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE) begin
                r_prescale <= prescale;
                r_par_en   <= PAR_EN;
            end
            r_err      <= (r_state == PARITY && w_bit_end) ? par_err : ((w_next == IDLE) ? 1'b0 : r_err);
            data_valid <= w_frame_end && !r_err && !stp_err;
`ifdef UART_RX_FRAME_ERR_EN
            frame_err  <= w_frame_end && (r_err || stp_err);
`endif
        end
    end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: directed frames with a data_valid scoreboard and cycle-by-cycle counter/strobe model
module tb_uart_rx_fsm;
    localparam int DW = 8;
    logic CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0;
    logic strt_glitch = 1'b0, par_err = 1'b0, stp_err = 1'b0;
    logic [4:0] prescale = 5'd8;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic dat_samp_en, strt_check_en, deser_en, par_check_en, stp_check_en, data_valid;
    logic [14:0] outs;
    int checks = 0, failures = 0, cyc = 0, n_deser = 0, n_par = 0;
    int q_dv[$];
`ifdef UART_RX_FRAME_ERR_EN
    logic frame_err;
    int q_fe[$];
`endif

    always #5 CLK = ~CLK;

    assign outs = {edge_cnt, bit_cnt, dat_samp_en, strt_check_en, deser_en, par_check_en, stp_check_en, data_valid};

    uart_rx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .RX_IN         (RX_IN),
        .PAR_EN        (PAR_EN),
        .prescale      (prescale),
        .strt_glitch   (strt_glitch),
        .par_err       (par_err),
        .stp_err       (stp_err),
        .edge_cnt      (edge_cnt),
        .bit_cnt       (bit_cnt),
        .dat_samp_en   (dat_samp_en),
        .strt_check_en (strt_check_en),
        .deser_en      (deser_en),
        .par_check_en  (par_check_en),
        .stp_check_en  (stp_check_en),
        .data_valid    (data_valid)
`ifdef UART_RX_FRAME_ERR_EN
        ,
        .frame_err     (frame_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        cyc++;
        @(negedge CLK);
        if (deser_en === 1'b1) n_deser++;
        if (par_check_en === 1'b1) n_par++;
        if (data_valid === 1'b1) chk("dv_cycle", cyc, q_dv.size() != 0 ? q_dv.pop_front() : 0);
`ifdef UART_RX_FRAME_ERR_EN
        if (frame_err === 1'b1) chk("fe_cycle", cyc, q_fe.size() != 0 ? q_fe.pop_front() : 0);
`endif
    endtask

    task automatic clear_in();
        RX_IN = 1'b1;
        strt_glitch = 1'b0;
        par_err = 1'b0;
        stp_err = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input int ps, input int pe, input int gl,
                              input int perr, input int serr, input int rst_off);
        int t, n, b, e, last, good;
        t = cyc;
        n = (2 + DW + pe) * ps;
        last = 1 + DW + pe;
        good = (perr == 0 && serr == 0) ? 1 : 0;
        prescale = 5'(ps);
        PAR_EN = pe != 0;
        RX_IN = 1'b0;
        n_deser = 0;
        n_par = 0;
        if (gl == 0 && rst_off < 0) begin
            if (good != 0) q_dv.push_back(t + n + 1);
`ifdef UART_RX_FRAME_ERR_EN
            else q_fe.push_back(t + n + 1);
`endif
        end
        for (int off = 0; off < n; off++) begin
            tick();
            b = off / ps;
            e = off % ps;
            chk("counters", 32'({edge_cnt, bit_cnt}), 32'({5'(e), 4'(b)}));
            chk("strobes", 32'({dat_samp_en, strt_check_en, deser_en, par_check_en, stp_check_en}),
                32'({1'b1, b == 0 && e == ps - 2, b >= 1 && b <= DW && e == ps - 2,
                     pe != 0 && b == DW + 1 && e == ps - 2, b == last && e == ps - 2}));
            prescale = 5'(ps ^ 3);
            PAR_EN = pe == 0;
            if (b == 0) RX_IN = gl != 0 && off >= 1;
            else if (b <= DW) RX_IN = d[b-1];
            else if (pe != 0 && b == DW + 1) RX_IN = ^d;
            else RX_IN = 1'b1;
            strt_glitch = gl != 0 && b == 0 && e == ps - 1;
            par_err = perr != 0 && pe != 0 && b == DW + 1 && e == ps - 1;
            stp_err = serr != 0 && b == last && e == ps - 1;
            if (off == rst_off) begin
                clear_in();
                RST = 1'b1;
                tick();
                chk("rst_mid_outs", 32'(outs), 0);
                RST = 1'b0;
                return;
            end
            if (gl != 0 && off == ps - 1) begin
                tick();
                clear_in();
                chk("glitch_idle", 32'({dat_samp_en, edge_cnt, bit_cnt}), 0);
                chk("glitch_no_deser", n_deser, 0);
                return;
            end
        end
        tick();
        clear_in();
        prescale = 5'(ps);
        chk("dv_slot", 32'(data_valid), good);
        chk("n_deser", n_deser, DW);
        chk("n_par", n_par, pe);
    endtask

    initial begin
        repeat (2) tick();
        chk("reset_outs", 32'(outs), 0);
        RST = 1'b0;
        repeat (2) tick();
        chk("idle_outs", 32'(outs), 0);
        send_frame(8'hA5, 8, 0, 0, 0, 0, -1);
        repeat (3) tick();
        send_frame(8'hA5, 8, 1, 0, 0, 0, -1);
        repeat (3) tick();
        send_frame(8'hA5, 8, 0, 1, 0, 0, -1);
        repeat (3) tick();
        send_frame(8'h3C, 8, 1, 0, 1, 0, -1);
        repeat (3) tick();
        send_frame(8'h3C, 8, 0, 0, 0, 1, -1);
        repeat (3) tick();
        send_frame(8'h5A, 8, 0, 0, 0, 0, -1);
        send_frame(8'hC3, 8, 0, 0, 0, 0, -1);
        repeat (3) tick();
        send_frame(8'h96, 8, 0, 0, 0, 0, 4 * 8 + 3);
        repeat (2) tick();
        send_frame(8'h96, 8, 0, 0, 0, 0, -1);
        repeat (3) tick();
        send_frame(8'h71, 8, 1, 0, 1, 0, 10 * 8 + 2);
        repeat (2) tick();
        send_frame(8'h71, 8, 1, 0, 0, 0, -1);
        repeat (3) tick();
        send_frame(8'h0F, 6, 1, 0, 0, 0, -1);
        repeat (3) tick();
        send_frame(8'hE1, 31, 0, 0, 0, 0, -1);
        repeat (4) tick();
        chk("dv_queue_empty", q_dv.size(), 0);
`ifdef UART_RX_FRAME_ERR_EN
        chk("fe_queue_empty", q_fe.size(), 0);
`endif
        chk("final_idle", 32'(outs), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
